// File: rtl/cm0_dbg_bpu_pkg.sv
// Shared constants for the instruction breakpoint unit: register map, MATCH
// encodings and CTRL bit positions.
package cm0_dbg_bpu_pkg;

  localparam int unsigned NcompMax = 8;

  localparam logic [4:0] RegCtrl     = 5'd0;
  localparam logic [4:0] RegStatus   = 5'd1;
  localparam logic [4:0] RegCompBase = 5'd2;
  localparam logic [4:0] RegCntBase  = 5'd10;

  typedef enum logic [1:0] {
    MatchNone  = 2'b00,
    MatchLower = 2'b01,
    MatchUpper = 2'b10,
    MatchBoth  = 2'b11
  } match_e;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlKeyBit    = 1;
  localparam int unsigned CtrlNumLsb    = 4;

endpackage

// File: rtl/cm0_dbg_bpu_comp.sv
// One breakpoint comparator slice: COMP/MATCH/ENABLE/ONCE, the pass counter
// and raw/hit generation.
module cm0_dbg_bpu_comp
  import cm0_dbg_bpu_pkg::*;
#(
  parameter int unsigned CNTW = 8,
  parameter bit          RAR  = 1'b0
) (
  input  logic        dclk,
  input  logic        dbg_reset_n,
  input  logic        advance,
  input  logic        match_en,
  input  logic [26:0] fetch_addr,
  input  logic        comp_we,
  input  logic        cnt_we,
  input  logic [31:0] wdata,
  output logic [31:0] comp_rdata,
  output logic [31:0] cnt_rdata,
  output logic        hit,
  output logic [1:0]  match_field
);

  match_e            match_q;
  logic [26:0]       comp_q;
  logic              en_q, en_d;
  logic              once_q, once_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              raw, cnt_zero, dec;
  logic              unused_wdata;

  assign raw      = en_q & (fetch_addr == comp_q) & match_en & (match_q != MatchNone);
  assign cnt_zero = (cnt_q == '0);
  assign hit      = advance & raw & cnt_zero;
  assign dec      = advance & raw & ~cnt_zero;

  // Register writes are applied last so they win over ONCE-clear and decrement.
  always_comb begin
    en_d   = en_q;
    once_d = once_q;
    cnt_d  = cnt_q;
    if (hit && once_q) en_d = 1'b0;
    if (comp_we) begin
      en_d   = wdata[0];
      once_d = wdata[1];
    end
    if (dec) cnt_d = cnt_q - 1'b1;
    if (cnt_we) cnt_d = wdata[CNTW-1:0];
  end

  always_ff @(posedge dclk or negedge dbg_reset_n) begin
    if (!dbg_reset_n) begin
      en_q   <= 1'b0;
      once_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      en_q   <= en_d;
      once_q <= once_d;
      cnt_q  <= cnt_d;
    end
  end

  if (RAR) begin : g_rar
    always_ff @(posedge dclk or negedge dbg_reset_n) begin
      if (!dbg_reset_n) begin
        match_q <= MatchBoth;
        comp_q  <= '1;
      end else if (comp_we) begin
        match_q <= match_e'(wdata[31:30]);
        comp_q  <= wdata[28:2];
      end
    end
  end else begin : g_norar
    always_ff @(posedge dclk) begin
      if (comp_we) begin
        match_q <= match_e'(wdata[31:30]);
        comp_q  <= wdata[28:2];
      end
    end
  end

  assign comp_rdata   = {match_q, 1'b0, comp_q, once_q, en_q};
  assign cnt_rdata    = 32'(cnt_q);
  assign match_field  = match_q;
  assign unused_wdata = wdata[29];

endmodule

// File: rtl/cm0_dbg_bpu_cnt.sv
// Instruction breakpoint unit top: CTRL/STATUS, PPB decode and read mux,
// hit priority encoder and registered match/hit-ID outputs.
module cm0_dbg_bpu_cnt
  import cm0_dbg_bpu_pkg::*;
#(
  parameter int unsigned NCOMP = 4,
  parameter int unsigned CNTW  = 8,
  parameter bit          RAR   = 1'b0
) (
  input  logic        dclk,
  input  logic        dbg_reset_n,
  input  logic        hready_i,
  input  logic [29:0] alu_haddr_31_2_i,
  input  logic        alu_dbg_trans_i,
  input  logic        ctl_hprot_i,
  input  logic        dbg_c_debugen_i,
  input  logic        ppb_sel_i,
  input  logic        ppb_write_i,
  input  logic [4:0]  ppb_addr_i,
  input  logic [31:0] slv_wdata_i,
  output logic [31:0] bpu_hrdata_o,
  output logic [1:0]  bpu_match_o,
  output logic [2:0]  bpu_hit_id_o
);

  if (NCOMP == 0) begin : g_absent
    logic unused;
    assign unused = ^{dclk, dbg_reset_n, hready_i, alu_haddr_31_2_i, alu_dbg_trans_i,
                      ctl_hprot_i, dbg_c_debugen_i, ppb_sel_i, ppb_write_i, ppb_addr_i,
                      slv_wdata_i};
    assign bpu_hrdata_o = '0;
    assign bpu_match_o  = '0;
    assign bpu_hit_id_o = '0;
  end else begin : g_unit
    logic             advance, match_en, wr;
    logic             ctrl_en_q;
    logic [NCOMP-1:0] status_q, status_d, status_clr;
    logic [NCOMP-1:0] hit;
    logic [1:0]       match_field [NCOMP];
    logic [31:0]      comp_rdata [NCOMP];
    logic [31:0]      cnt_rdata [NCOMP];
    logic [1:0]       match_q, match_d;
    logic [2:0]       id_q, id_d;

    assign advance  = hready_i;
    // Only instruction fetches from the code region [31:29]==0 are considered.
    assign match_en = dbg_c_debugen_i & ctrl_en_q & alu_dbg_trans_i & ~ctl_hprot_i &
                      (alu_haddr_31_2_i[29:27] == 3'b000);
    assign wr       = ppb_sel_i & ppb_write_i;

    for (genvar g = 0; g < NCOMP; g++) begin : g_comp
      cm0_dbg_bpu_comp #(
        .CNTW (CNTW),
        .RAR  (RAR)
      ) u_comp (
        .dclk        (dclk),
        .dbg_reset_n (dbg_reset_n),
        .advance     (advance),
        .match_en    (match_en),
        .fetch_addr  (alu_haddr_31_2_i[26:0]),
        .comp_we     (wr && (ppb_addr_i == RegCompBase + 5'(g))),
        .cnt_we      (wr && (ppb_addr_i == RegCntBase + 5'(g))),
        .wdata       (slv_wdata_i),
        .comp_rdata  (comp_rdata[g]),
        .cnt_rdata   (cnt_rdata[g]),
        .hit         (hit[g]),
        .match_field (match_field[g])
      );
    end

    // A new hit wins over a same-cycle W1C of the same bit.
    assign status_clr = (wr && (ppb_addr_i == RegStatus)) ? slv_wdata_i[NCOMP-1:0] : '0;
    assign status_d   = hit | (status_q & ~status_clr);

    always_comb begin
      match_d = '0;
      id_d    = '0;
      for (int i = int'(NCOMP) - 1; i >= 0; i--) begin
        if (hit[i]) begin
          match_d = match_d | match_field[i];
          id_d    = 3'(i);
        end
      end
    end

    always_ff @(posedge dclk or negedge dbg_reset_n) begin
      if (!dbg_reset_n) begin
        ctrl_en_q <= 1'b0;
        status_q  <= '0;
        match_q   <= '0;
        id_q      <= '0;
      end else begin
        if (wr && (ppb_addr_i == RegCtrl) && slv_wdata_i[CtrlKeyBit]) begin
          ctrl_en_q <= slv_wdata_i[CtrlEnableBit];
        end
        status_q <= status_d;
        if (advance) begin
          match_q <= match_d;
          id_q    <= id_d;
        end
      end
    end

    always_comb begin
      bpu_hrdata_o = '0;
      if (ppb_sel_i) begin
        if (ppb_addr_i == RegCtrl) begin
          bpu_hrdata_o[CtrlNumLsb +: 4]  = 4'(NCOMP);
          bpu_hrdata_o[CtrlEnableBit]    = ctrl_en_q;
        end else if (ppb_addr_i == RegStatus) begin
          bpu_hrdata_o = 32'(status_q);
        end
        for (int i = 0; i < int'(NCOMP); i++) begin
          if (ppb_addr_i == RegCompBase + 5'(i)) bpu_hrdata_o = comp_rdata[i];
          if (ppb_addr_i == RegCntBase + 5'(i))  bpu_hrdata_o = cnt_rdata[i];
        end
      end
    end

    assign bpu_match_o  = match_q;
    assign bpu_hit_id_o = id_q;
  end

endmodule

// File: tb/tb_cm0_dbg_bpu_cnt.sv
// Self-checking bench for cm0_dbg_bpu_cnt: scenario tasks plus an output
// scoreboard fed at drive time and drained one cycle later.
module tb_cm0_dbg_bpu_cnt;

  logic        dclk = 1'b0;
  logic        dbg_reset_n;
  logic        hready_i;
  logic [29:0] alu_haddr_31_2_i;
  logic        alu_dbg_trans_i;
  logic        ctl_hprot_i;
  logic        dbg_c_debugen_i;
  logic        ppb_sel_i;
  logic        ppb_write_i;
  logic [4:0]  ppb_addr_i;
  logic [31:0] slv_wdata_i;
  logic [31:0] bpu_hrdata_o, abs_hrdata;
  logic [1:0]  bpu_match_o, abs_match;
  logic [2:0]  bpu_hit_id_o, abs_hit_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] m;
    logic [2:0] id;
    string      nm;
  } exp_t;
  exp_t exp_q[$];
  exp_t cur;

  always #5 dclk = ~dclk;

  cm0_dbg_bpu_cnt #(.NCOMP(4), .CNTW(8), .RAR(1'b0)) u_dut (
    .dclk             (dclk),
    .dbg_reset_n      (dbg_reset_n),
    .hready_i         (hready_i),
    .alu_haddr_31_2_i (alu_haddr_31_2_i),
    .alu_dbg_trans_i  (alu_dbg_trans_i),
    .ctl_hprot_i      (ctl_hprot_i),
    .dbg_c_debugen_i  (dbg_c_debugen_i),
    .ppb_sel_i        (ppb_sel_i),
    .ppb_write_i      (ppb_write_i),
    .ppb_addr_i       (ppb_addr_i),
    .slv_wdata_i      (slv_wdata_i),
    .bpu_hrdata_o     (bpu_hrdata_o),
    .bpu_match_o      (bpu_match_o),
    .bpu_hit_id_o     (bpu_hit_id_o)
  );

  cm0_dbg_bpu_cnt #(.NCOMP(0), .CNTW(8), .RAR(1'b0)) u_absent (
    .dclk             (dclk),
    .dbg_reset_n      (dbg_reset_n),
    .hready_i         (hready_i),
    .alu_haddr_31_2_i (alu_haddr_31_2_i),
    .alu_dbg_trans_i  (alu_dbg_trans_i),
    .ctl_hprot_i      (ctl_hprot_i),
    .dbg_c_debugen_i  (dbg_c_debugen_i),
    .ppb_sel_i        (ppb_sel_i),
    .ppb_write_i      (ppb_write_i),
    .ppb_addr_i       (ppb_addr_i),
    .slv_wdata_i      (slv_wdata_i),
    .bpu_hrdata_o     (abs_hrdata),
    .bpu_match_o      (abs_match),
    .bpu_hit_id_o     (abs_hit_id)
  );

  // Scoreboard: each step pushes one expectation that lands on the next edge.
  always @(posedge dclk) begin
    #2;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (bpu_match_o !== cur.m || bpu_hit_id_o !== cur.id) begin
        errors++;
        $display("FAIL %s: match=%b id=%0d, required match=%b id=%0d",
                 cur.nm, bpu_match_o, bpu_hit_id_o, cur.m, cur.id);
      end
    end
  end

  task automatic idle();
    alu_dbg_trans_i = 1'b0;
    ctl_hprot_i     = 1'b0;
    dbg_c_debugen_i = 1'b1;
    hready_i        = 1'b1;
    ppb_sel_i       = 1'b0;
    ppb_write_i     = 1'b0;
    ppb_addr_i      = '0;
    slv_wdata_i     = '0;
  endtask

  task automatic step(input logic [31:0] fa, input logic hp, input logic de, input logic hr,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [1:0] em, input logic [2:0] eid, input string nm);
    alu_haddr_31_2_i = fa[31:2];
    alu_dbg_trans_i  = 1'b1;
    ctl_hprot_i      = hp;
    dbg_c_debugen_i  = de;
    hready_i         = hr;
    ppb_sel_i        = we;
    ppb_write_i      = we;
    ppb_addr_i       = wa;
    slv_wdata_i      = wd;
    exp_q.push_back('{em, eid, nm});
    @(negedge dclk);
    idle();
  endtask

  task automatic fetch(input logic [31:0] fa, input logic [1:0] em, input logic [2:0] eid,
                       input string nm);
    step(fa, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, em, eid, nm);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ppb_sel_i   = 1'b1;
    ppb_write_i = 1'b1;
    ppb_addr_i  = a;
    slv_wdata_i = d;
    @(negedge dclk);
    idle();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d, output logic [31:0] ad);
    ppb_sel_i   = 1'b1;
    ppb_write_i = 1'b0;
    ppb_addr_i  = a;
    #1;
    d  = bpu_hrdata_o;
    ad = abs_hrdata;
    ppb_sel_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v, av;
    checks++;
    if (bpu_match_o !== 2'b00 || bpu_hit_id_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_out: match=%b id=%0d, required 00/0", bpu_match_o, bpu_hit_id_o);
    end
    rd(5'd0, v, av);
    checks++;
    if (v !== 32'h40) begin errors++; $display("FAIL reset_ctrl: %h required 00000040", v); end
    rd(5'd1, v, av);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_status: %h required 0", v); end
    rd(5'd10, v, av);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_cnt0: %h required 0", v); end
  endtask

  task automatic test_basic();
    logic [31:0] v, av;
    wr(5'd0, 32'h3);
    wr(5'd4, 32'h4000_1001);
    wr(5'd12, 32'h0);
    rd(5'd0, v, av);
    checks++;
    if (v !== 32'h41) begin errors++; $display("FAIL ctrl_en: %h required 00000041", v); end
    fetch(32'h1000, 2'b01, 3'd2, "basic_hit");
    rd(5'd1, v, av);
    checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL basic_status: %h required 00000004", v); end
    wr(5'd1, 32'h4);
    rd(5'd1, v, av);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL status_w1c: %h required 0", v); end
  endtask

  task automatic test_count();
    logic [31:0] v, av;
    wr(5'd10, 32'd3);
    wr(5'd2, 32'hC000_2001);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) fetch(32'h2000, 2'b00, 3'd0, "count_pass");
      else       fetch(32'h2000, 2'b11, 3'd0, "count_hit");
      rd(5'd10, v, av);
      checks++;
      if (v !== 32'(k < 3 ? 2 - k : 0)) begin
        errors++;
        $display("FAIL cnt0_step%0d: %0d required %0d", k, v, (k < 3 ? 2 - k : 0));
      end
    end
    wr(5'd1, 32'hF);
  endtask

  task automatic test_once();
    logic [31:0] v, av;
    wr(5'd3, 32'h8000_3003);
    fetch(32'h3000, 2'b10, 3'd1, "once_first");
    rd(5'd3, v, av);
    checks++;
    if (v !== 32'h8000_3002) begin errors++; $display("FAIL once_comp1: %h required 80003002", v); end
    fetch(32'h3000, 2'b00, 3'd0, "once_second");
    rd(5'd1, v, av);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL once_status: %h required 00000002", v); end
    wr(5'd1, 32'hF);
  endtask

  task automatic test_multi();
    logic [31:0] v, av;
    wr(5'd2, 32'h4000_4001);
    wr(5'd5, 32'h8000_4001);
    fetch(32'h4000, 2'b11, 3'd0, "multi_hit");
    rd(5'd1, v, av);
    checks++;
    if (v !== 32'h9) begin errors++; $display("FAIL multi_status: %h required 00000009", v); end
    wr(5'd1, 32'hF);
  endtask

  task automatic test_collision();
    logic [31:0] v, av;
    wr(5'd3, 32'h8000_5001);
    step(32'h5000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h2, 2'b10, 3'd1, "w1c_vs_hit");
    rd(5'd1, v, av);
    checks++;
    if (v !== 32'h2) begin errors++; $display("FAIL w1c_vs_hit_status: %h required 00000002", v); end
    wr(5'd3, 32'h8000_5003);
    step(32'h5000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h8000_5003, 2'b10, 3'd1, "once_vs_write");
    rd(5'd3, v, av);
    checks++;
    if (v !== 32'h8000_5003) begin errors++; $display("FAIL once_vs_write: %h required 80005003", v); end
    wr(5'd5, 32'h4000_6001);
    wr(5'd13, 32'd5);
    step(32'h6000, 1'b0, 1'b1, 1'b1, 1'b1, 5'd13, 32'd7, 2'b00, 3'd0, "cnt_write_vs_dec");
    rd(5'd13, v, av);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL cnt3_write_wins: %0d required 7", v); end
    wr(5'd1, 32'hF);
  endtask

  task automatic test_qual();
    wr(5'd2, 32'h4000_0001);
    step(32'h1000, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 3'd0, "qual_hprot");
    step(32'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 2'b00, 3'd0, "qual_debugen");
    fetch(32'h2000_0000, 2'b00, 3'd0, "qual_region");
    fetch(32'h0000_0000, 2'b01, 3'd0, "qual_addr0");
  endtask

  task automatic test_hold();
    logic [31:0] v, av;
    fetch(32'h1000, 2'b01, 3'd2, "hold_setup");
    step(32'h6000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 2'b01, 3'd2, "hold_outputs");
    rd(5'd13, v, av);
    checks++;
    if (v !== 32'd7) begin errors++; $display("FAIL hold_cnt3: %0d required 7", v); end
  endtask

  task automatic test_midreset();
    logic [31:0] v, av;
    wr(5'd2, 32'hC000_7001);
    wr(5'd10, 32'd3);
    fetch(32'h7000, 2'b00, 3'd0, "mid_pass");
    rd(5'd10, v, av);
    checks++;
    if (v !== 32'd2) begin errors++; $display("FAIL mid_cnt0: %0d required 2", v); end
    @(negedge dclk);
    fetch(32'h1000, 2'b01, 3'd2, "mid_hit");
    dbg_reset_n = 1'b0;
    #1;
    checks++;
    if (bpu_match_o !== 2'b00 || bpu_hit_id_o !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_out: match=%b id=%0d, required 00/0", bpu_match_o, bpu_hit_id_o);
    end
    rd(5'd10, v, av);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL mid_reset_cnt0: %0d required 0", v); end
    rd(5'd0, v, av);
    checks++;
    if (v !== 32'h40) begin errors++; $display("FAIL mid_reset_ctrl: %h required 00000040", v); end
    rd(5'd1, v, av);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL mid_reset_status: %h required 0", v); end
    @(negedge dclk);
    dbg_reset_n = 1'b1;
  endtask

  task automatic test_absent();
    logic [31:0] v, av;
    logic [4:0]  addrs [4];
    addrs = '{5'd0, 5'd1, 5'd2, 5'd10};
    wr(5'd0, 32'h3);
    wr(5'd4, 32'h4000_1001);
    for (int k = 0; k < 4; k++) begin
      rd(addrs[k], v, av);
      checks++;
      if (av !== 32'h0) begin
        errors++;
        $display("FAIL absent_read%0d: %h required 0", addrs[k], av);
      end
    end
    fetch(32'h1000, 2'b01, 3'd2, "absent_main_hit");
    checks++;
    if (abs_match !== 2'b00 || abs_hit_id !== 3'd0) begin
      errors++;
      $display("FAIL absent_out: match=%b id=%0d, required 00/0", abs_match, abs_hit_id);
    end
  endtask

  initial begin
    alu_haddr_31_2_i = '0;
    idle();
    dbg_reset_n = 1'b0;
    repeat (2) @(negedge dclk);
    dbg_reset_n = 1'b1;
    @(negedge dclk);
    test_reset();
    test_basic();
    test_count();
    test_once();
    test_multi();
    test_collision();
    test_qual();
    test_hold();
    test_midreset();
    test_absent();
    @(posedge dclk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
